encoder_gate_dec: RTL and testbench
===================================

ENCODER_GATE_DEC -- requirements
Module: encoder_gate_dec

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4, giving the number of cycles a decoded line is held high (legal 1..255).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 1, giving the number of forced-low cycles after each hold (legal 0..255).
REQ-003 Port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 Port code, input, 2, encoded value from an encoder_gate-compatible source: 00 none, 01 line c, 10 line b, 11 line a.
REQ-006 Port in_valid, input, 1, code is valid this cycle.
REQ-007 Port in_ready, output, 1, decoder accepts a code this cycle.
REQ-008 Port a, output, 1, decoded line a, registered.
REQ-009 Port b, output, 1, decoded line b, registered.
REQ-010 Port c, output, 1, decoded line c, registered.
REQ-011 Port busy, output, 1, high while in HOLD or GAP.

Function
REQ-012 FSM states SHALL be IDLE, HOLD and GAP.
REQ-013 in_ready SHALL be high in IDLE only; a transfer occurs on a rising edge where in_valid and in_ready are both high.
REQ-014 Code 00 accepted in IDLE SHALL leave the FSM in IDLE with a, b, c low.
REQ-015 A non-zero code accepted at edge N SHALL drive exactly one of a/b/c high from edge N, i.e. visible in the cycle after acceptance; latency 1 cycle.
REQ-016 The decoded line SHALL stay high for exactly HOLD_CYCLES cycles, then all lines go low on the same edge the FSM leaves HOLD.
REQ-017 HOLD SHALL go to GAP when GAP_CYCLES > 0, otherwise directly to IDLE.
REQ-018 GAP SHALL last exactly GAP_CYCLES cycles with a, b, c low, then go to IDLE.
REQ-019 At most one of a, b, c SHALL be high in any cycle.
REQ-020 in_valid or code changes during HOLD or GAP SHALL be ignored; the held code is not altered.
REQ-021 The hold/gap down-counter SHALL be 8 bits and SHALL never wrap; it is loaded at state entry and the state exits when it reaches 1.
REQ-022 With GAP_CYCLES = 0, a new code SHALL be acceptable in the cycle immediately after the hold ends, giving back-to-back holds separated by one low cycle in IDLE.

Reset
REQ-023 While rst_n is low, the FSM SHALL be IDLE, counters 0, and a, b, c, busy low with in_ready high once reset is released.
REQ-024 rst_n asserted mid-HOLD or mid-GAP SHALL clear all outputs immediately, without waiting for clk.
REQ-025 The first transfer SHALL be possible on the first rising edge after rst_n is released.

Configuration
REQ-026 With macro ENCODER_GATE_DEC_EVCNT_EN defined, the block SHALL add output ev_cnt [7:0], counting accepted non-zero codes, saturating at 255 and cleared by reset.
REQ-027 Without ENCODER_GATE_DEC_EVCNT_EN, port ev_cnt and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-028 Reset, then code=11 with in_valid for 1 cycle -> a high for exactly 4 cycles starting the cycle after acceptance, then 1 low GAP cycle, then in_ready=1.
REQ-029 Sweep codes 00, 01, 10, 11, each a single transfer -> 00 gives no output and no busy; 01->c, 10->b, 11->a, each 4 cycles, never two lines high at once.
REQ-030 Hold in_valid=1 continuously with code toggling during HOLD -> only the code sampled at acceptance is decoded; the next accept occurs after 4 hold cycles plus 1 gap cycle.
REQ-031 Pull rst_n low 2 cycles into HOLD of code=10 -> b falls with no clk edge; after release, in_ready=1 and the next code=01 decodes normally.
REQ-032 GAP_CYCLES=0, HOLD_CYCLES=1, continuous valid code=01 -> c pattern is 1,0,1,0...
REQ-033 Macro defined, 300 non-zero transfers -> ev_cnt reads 255; 00 codes never increment it; after reset it reads 0.

Source files
------------

// File: rtl/encoder_gate_dec.sv
// encoder_gate_dec: 2-bit code to one-hot a/b/c line decoder with hold/gap pulse shaping.
// Optional event counter output ev_cnt enabled by macro ENCODER_GATE_DEC_EVCNT_EN.
module encoder_gate_dec #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] code,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       a,
  output logic       b,
  output logic       c,
`ifdef ENCODER_GATE_DEC_EVCNT_EN
  output logic [7:0] ev_cnt,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  // out-of-range parameters are clamped into the 8-bit counter range
  localparam logic [7:0] HOLD_LD =
    (HOLD_CYCLES < 1)   ? 8'd1   :
    (HOLD_CYCLES > 255) ? 8'd255 : 8'(HOLD_CYCLES);
  localparam logic [7:0] GAP_LD =
    (GAP_CYCLES < 0)   ? 8'd0   :
    (GAP_CYCLES > 255) ? 8'd255 : 8'(GAP_CYCLES);
  localparam bit HAS_GAP = (GAP_LD != 8'd0);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] line_q, line_d;
  logic       busy_q, busy_d;
  logic [2:0] dec_line;
  logic       accept;
  logic       last;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt_q <= 8'd1);

  assign a    = line_q[2];
  assign b    = line_q[1];
  assign c    = line_q[0];
  assign busy = busy_q;

  // map the encoded value onto its one-hot output line
  always_comb begin
    dec_line = 3'b000;
    unique case (1'b1)
      (code == 2'b11): dec_line = 3'b100;
      (code == 2'b10): dec_line = 3'b010;
      (code == 2'b01): dec_line = 3'b001;
      default:         dec_line = 3'b000;
    endcase
  end

  // next-state, down-counter and registered line values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (accept && (code != 2'b00)) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          line_d  = dec_line;
          busy_d  = 1'b1;
        end
      end
      HOLD: begin
        if (last) begin
          line_d = 3'b000;
          if (HAS_GAP) begin
            state_d = GAP;
            cnt_d   = GAP_LD;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        line_d = 3'b000;
        if (last) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        line_d  = 3'b000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      line_q  <= 3'b000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
    end
  end

`ifdef ENCODER_GATE_DEC_EVCNT_EN
  logic [7:0] ev_q, ev_d;

  assign ev_cnt = ev_q;

  // saturating count of accepted non-zero codes
  always_comb begin
    ev_d = ev_q;
    if (accept && (code != 2'b00) && (ev_q != 8'hFF)) begin
      ev_d = ev_q + 8'd1;
    end
  end

  // event counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q <= 8'd0;
    end else begin
      ev_q <= ev_d;
    end
  end
`endif

`ifndef SYNTHESIS
  // decoded lines stay mutually exclusive
  a_onehot: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(line_q));

  // the counter is never empty while the FSM is active
  a_no_wrap: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q != IDLE) |-> (cnt_q != 8'd0));

  // lines are only driven while holding
  a_line_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    (line_q != 3'b000) |-> (state_q == HOLD));
`endif

endmodule

// File: tb/tb_encoder_gate_dec.sv
// tb_encoder_gate_dec: table-driven and scoreboard checks for encoder_gate_dec.
// Second instance covers HOLD_CYCLES=1, GAP_CYCLES=0 back-to-back behaviour.
module tb_encoder_gate_dec;

  logic       clk;
  logic       rst_n;
  logic [1:0] code_i;
  logic       valid_i;
  logic       rdy, a, b, c, busy;
  logic [1:0] code2;
  logic       valid2;
  logic       rdy2, a2, b2, c2, busy2;
`ifdef ENCODER_GATE_DEC_EVCNT_EN
  logic [7:0] ev_cnt;
  logic [7:0] ev_cnt2;
  int         exp_ev;
`endif

  typedef struct packed {
    logic [2:0] lines;
    logic       busy;
    logic       rdy;
  } exp_t;

  typedef struct {
    logic [1:0] code;
    logic [2:0] lines;
  } vec_t;

  exp_t q[$];
  vec_t vecs[6];
  int   checks;
  int   errors;

  encoder_gate_dec #(
    .HOLD_CYCLES(4),
    .GAP_CYCLES (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .code    (code_i),
    .in_valid(valid_i),
    .in_ready(rdy),
    .a       (a),
    .b       (b),
    .c       (c),
`ifdef ENCODER_GATE_DEC_EVCNT_EN
    .ev_cnt  (ev_cnt),
`endif
    .busy    (busy)
  );

  encoder_gate_dec #(
    .HOLD_CYCLES(1),
    .GAP_CYCLES (0)
  ) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .code    (code2),
    .in_valid(valid2),
    .in_ready(rdy2),
    .a       (a2),
    .b       (b2),
    .c       (c2),
`ifdef ENCODER_GATE_DEC_EVCNT_EN
    .ev_cnt  (ev_cnt2),
`endif
    .busy    (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp,
               $time);
    end
  endtask

  // expected per-cycle outputs for one transfer with hold 4 / gap 1
  task automatic push_exp(input logic [2:0] lines);
    if (lines != 3'b000) begin
      for (int i = 0; i < 4; i++) q.push_back('{lines, 1'b1, 1'b0});
      q.push_back('{3'b000, 1'b1, 1'b0});
    end
    q.push_back('{3'b000, 1'b0, 1'b1});
  endtask

  task automatic drain(input string name);
    exp_t e;
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      chk(name, {3'b000, a, b, c, busy, rdy}, {3'b000, e});
      chk("onehot", {7'd0, $countones({a, b, c}) <= 1}, 8'd1);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      errors++;
      $display("FAIL wait_ready: got in_ready=0 expected 1 within 50");
    end
  endtask

  task automatic do_xfer(input string name, input logic [1:0] cd,
                         input logic [2:0] lines);
    wait_ready();
    code_i  = cd;
    valid_i = 1'b1;
    push_exp(lines);
`ifdef ENCODER_GATE_DEC_EVCNT_EN
    if (cd != 2'b00 && exp_ev < 255) exp_ev++;
`endif
    @(posedge clk);
    #1 valid_i = 1'b0;
    drain(name);
  endtask

  function automatic logic [2:0] line_of(input logic [1:0] cd);
    logic [2:0] r;
    r = 3'b000;
    if (cd == 2'b11) r = 3'b100;
    if (cd == 2'b10) r = 3'b010;
    if (cd == 2'b01) r = 3'b001;
    return r;
  endfunction

  initial begin
    exp_t e;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    code_i  = 2'b00;
    valid_i = 1'b0;
    code2   = 2'b00;
    valid2  = 1'b0;
`ifdef ENCODER_GATE_DEC_EVCNT_EN
    exp_ev  = 0;
`endif

    vecs[0] = '{2'b11, 3'b100};
    vecs[1] = '{2'b00, 3'b000};
    vecs[2] = '{2'b01, 3'b001};
    vecs[3] = '{2'b10, 3'b010};
    vecs[4] = '{2'b11, 3'b100};
    vecs[5] = '{2'b01, 3'b001};

    repeat (3) @(negedge clk);
    chk("reset_out", {4'd0, a, b, c, busy}, 8'd0);
    chk("reset_out2", {4'd0, a2, b2, c2, busy2}, 8'd0);
    rst_n = 1'b1;
    chk("reset_rdy", {7'd0, rdy}, 8'd1);
`ifdef ENCODER_GATE_DEC_EVCNT_EN
    chk("reset_ev", ev_cnt, 8'd0);
`endif

    // table sweep; first entry is accepted on the first edge after release
    for (int i = 0; i < 6; i++) begin
      do_xfer($sformatf("vec%0d", i), vecs[i].code, vecs[i].lines);
    end

    // continuous valid with code toggling during hold/gap
    wait_ready();
    code_i  = 2'b11;
    valid_i = 1'b1;
    push_exp(3'b100);
`ifdef ENCODER_GATE_DEC_EVCNT_EN
    exp_ev++;
`endif
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      chk("toggle", {3'b000, a, b, c, busy, rdy}, {3'b000, e});
      if (q.size() > 0) code_i = 2'($urandom_range(0, 3));
    end
    code_i = 2'b01;
    push_exp(3'b001);
`ifdef ENCODER_GATE_DEC_EVCNT_EN
    exp_ev++;
`endif
    @(posedge clk);
    #1 valid_i = 1'b0;
    drain("toggle_next");

`ifdef ENCODER_GATE_DEC_EVCNT_EN
    chk("ev_count", ev_cnt, 8'(exp_ev));
    do_xfer("ev_zero", 2'b00, 3'b000);
    chk("ev_zero", ev_cnt, 8'(exp_ev));
    for (int i = 0; i < 300; i++) begin
      logic [1:0] cd;
      cd = 2'($urandom_range(1, 3));
      do_xfer("ev_loop", cd, line_of(cd));
    end
    chk("ev_sat", ev_cnt, 8'd255);
    do_xfer("ev_zero_sat", 2'b00, 3'b000);
    chk("ev_sat_zero", ev_cnt, 8'd255);
`endif

    // asynchronous reset in the middle of a hold
    wait_ready();
    code_i  = 2'b10;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_b1", {6'd0, b, busy}, 8'd3);
    @(negedge clk);
    chk("pre_rst_b2", {6'd0, b, busy}, 8'd3);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {4'd0, a, b, c, busy}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_rdy", {7'd0, rdy}, 8'd1);
`ifdef ENCODER_GATE_DEC_EVCNT_EN
    chk("post_rst_ev", ev_cnt, 8'd0);
    exp_ev = 0;
`endif
    do_xfer("post_rst", 2'b01, 3'b001);

    // hold 1 / gap 0 with continuous valid gives alternating c
    code2  = 2'b01;
    valid2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d", i), {3'd0, a2, b2, c2, busy2, rdy2},
          (i % 2 == 0) ? 8'b0000_0110 : 8'b0000_0001);
    end
    valid2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks,
             errors);
    $finish;
  end

endmodule
